// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Shares the single register-file write port between the pipeline writeback
// stage and an out-of-order multi-cycle unit (divider/load). It also keeps a
// busy scoreboard of destinations owned by in-flight multi-cycle ops, and it
// stalls decode on RAW/WAW hazards against those destinations.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pipe_we/pipe_wR/pipe_wD  WB write request; pipe_hold=1 -> re-present next cycle
//   long_valid/long_wR/long_wD  multi-cycle result; long_ready accepts it
//                            (transfer = long_valid & long_ready, same cycle)
//   issue_valid/issue_rd     multi-cycle op issued; marks issue_rd busy
//   id_rR1/id_rR2/id_wR      decode operands; id_stall on any busy hit
//   rf_we/rf_wR/rf_wD        register-file write port (commits at the grant edge)
//   busy_vec                 current scoreboard, for debug
//
// Handshake: a long result moves on any cycle where long_valid & long_ready.
// A WB request that sees pipe_hold=1 was not written and must be re-presented.
module rf_wb_arbiter #(
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_we,
    input  logic [4:0]    pipe_wR,
    input  logic [DW-1:0] pipe_wD,
    output logic          pipe_hold,
    input  logic          long_valid,
    input  logic [4:0]    long_wR,
    input  logic [DW-1:0] long_wD,
    output logic          long_ready,
    input  logic          issue_valid,
    input  logic [4:0]    issue_rd,
    input  logic [4:0]    id_rR1,
    input  logic [4:0]    id_rR2,
    input  logic [4:0]    id_wR,
    output logic          id_stall,
    output logic          rf_we,
    output logic [4:0]    rf_wR,
    output logic [DW-1:0] rf_wD,
    output logic [31:0]   busy_vec
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  cnt;
    logic [31:0] busy;
    logic [31:0] busy_nxt;
    logic        pipe_req;
    logic        force_mode;
    logic        long_sel;
    logic        long_xfer;

    // Arbitration and port mux. Everything is forced to 0 while rst is high.
    always_comb begin
        pipe_req   = pipe_we && (pipe_wR != 5'd0);
        force_mode = (cnt == LIMIT);
        long_sel   = 1'b0;
        pipe_hold  = 1'b0;
        long_ready = 1'b0;
        rf_we      = 1'b0;
        rf_wR      = 5'd0;
        rf_wD      = '0;
        id_stall   = 1'b0;
        busy_vec   = 32'd0;
        if (!rst) begin
            if (force_mode) begin
                // Starved long unit owns the port; WB must retry.
                long_sel   = 1'b1;
                long_ready = 1'b1;
                pipe_hold  = pipe_req;
            end else if (pipe_req) begin
                long_sel   = 1'b0;
            end else begin
                long_sel   = 1'b1;
                long_ready = long_valid;
            end

            if (long_sel) begin
                // A long result to x0 is accepted but never written.
                if (long_valid && (long_wR != 5'd0)) begin
                    rf_we = 1'b1;
                    rf_wR = long_wR;
                    rf_wD = long_wD;
                end
            end else if (pipe_req) begin
                rf_we = 1'b1;
                rf_wR = pipe_wR;
                rf_wD = pipe_wD;
            end

            // Uses the pre-edge scoreboard, so a reader still stalls during
            // the cycle of the releasing write and sees the value next cycle.
            id_stall = busy[id_rR1] | busy[id_rR2] | busy[id_wR];
            busy_vec = busy;
        end
    end

    assign long_xfer = long_valid & long_ready;

    // Clear first, then set, so a same-cycle issue to the released register wins.
    always_comb begin
        busy_nxt = busy;
        if (long_xfer) begin
            busy_nxt[long_wR] = 1'b0;
        end
        if (issue_valid) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 32'd0;
            cnt  <= 4'd0;
        end else begin
            busy <= busy_nxt;
            if (long_xfer) begin
                cnt <= 4'd0;
            end else if (long_valid && !long_ready && (cnt != LIMIT)) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          pipe_we;
    logic [4:0]    pipe_wR;
    logic [DW-1:0] pipe_wD;
    logic          pipe_hold;
    logic          long_valid;
    logic [4:0]    long_wR;
    logic [DW-1:0] long_wD;
    logic          long_ready;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic [4:0]    id_rR1;
    logic [4:0]    id_rR2;
    logic [4:0]    id_wR;
    logic          id_stall;
    logic          rf_we;
    logic [4:0]    rf_wR;
    logic [DW-1:0] rf_wD;
    logic [31:0]   busy_vec;

    rf_wb_arbiter #(.DW(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_wR(pipe_wR), .pipe_wD(pipe_wD), .pipe_hold(pipe_hold),
        .long_valid(long_valid), .long_wR(long_wR), .long_wD(long_wD), .long_ready(long_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .id_rR1(id_rR1), .id_rR2(id_rR2), .id_wR(id_wR), .id_stall(id_stall),
        .rf_we(rf_we), .rf_wR(rf_wR), .rf_wD(rf_wD), .busy_vec(busy_vec)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vectors ----------------
    typedef struct packed {
        logic          hold;
        logic          lready;
        logic          stall;
        logic          we;
        logic [4:0]    wr;
        logic [DW-1:0] wd;
        logic [31:0]   busy;
    } exp_t;

    typedef struct packed {
        logic          rst;
        logic          pwe;
        logic [4:0]    pwr;
        logic [DW-1:0] pwd;
        logic          lv;
        logic [4:0]    lwr;
        logic [DW-1:0] lwd;
        logic          iv;
        logic [4:0]    ird;
        logic [4:0]    r1;
        logic [4:0]    r2;
        logic [4:0]    w;
        exp_t          e;
    } vec_t;

    localparam int EW = $bits(exp_t);

    vec_t           tbl[$];
    logic [EW-1:0]  exp_q[$];
    int             n_checks = 0;
    int             n_fail   = 0;

    function automatic vec_t mk(
        input logic rst_i, input logic pwe, input logic [4:0] pwr, input logic [DW-1:0] pwd,
        input logic lv, input logic [4:0] lwr, input logic [DW-1:0] lwd,
        input logic iv, input logic [4:0] ird,
        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] w,
        input logic e_hold, input logic e_lr, input logic e_stall, input logic e_we,
        input logic [4:0] e_wr, input logic [DW-1:0] e_wd, input logic [31:0] e_busy);
        vec_t v;
        v.rst = rst_i; v.pwe = pwe; v.pwr = pwr; v.pwd = pwd;
        v.lv = lv; v.lwr = lwr; v.lwd = lwd; v.iv = iv; v.ird = ird;
        v.r1 = r1; v.r2 = r2; v.w = w;
        v.e.hold = e_hold; v.e.lready = e_lr; v.e.stall = e_stall; v.e.we = e_we;
        v.e.wr = e_wr; v.e.wd = e_wd; v.e.busy = e_busy;
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input vec_t v);
        @(posedge clk);
        #1;
        rst = v.rst;
        pipe_we = v.pwe; pipe_wR = v.pwr; pipe_wD = v.pwd;
        long_valid = v.lv; long_wR = v.lwr; long_wD = v.lwd;
        issue_valid = v.iv; issue_rd = v.ird;
        id_rR1 = v.r1; id_rR2 = v.r2; id_wR = v.w;
        exp_q.push_back(v.e);
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk1(input string name, input int cyc, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, cyc, act, req);
        end
    endtask

    task automatic sample(input int cyc);
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL queue step %0d: got empty expected queue entry", cyc);
        end else begin
            e = exp_t'(exp_q.pop_front());
            chk1("pipe_hold",  cyc, DW'(pipe_hold),  DW'(e.hold));
            chk1("long_ready", cyc, DW'(long_ready), DW'(e.lready));
            chk1("id_stall",   cyc, DW'(id_stall),   DW'(e.stall));
            chk1("rf_we",      cyc, DW'(rf_we),      DW'(e.we));
            chk1("rf_wR",      cyc, DW'(rf_wR),      DW'(e.wr));
            chk1("rf_wD",      cyc, rf_wD,           e.wd);
            chk1("busy_vec",   cyc, DW'(busy_vec),   DW'(e.busy));
        end
    endtask

    localparam logic [DW-1:0] DA = 32'hA0A0_0001;
    localparam logic [DW-1:0] DB = 32'hB0B0_0002;

    initial begin
        int step;
        rst = 1'b1; pipe_we = 0; pipe_wR = 0; pipe_wD = 0;
        long_valid = 0; long_wR = 0; long_wD = 0;
        issue_valid = 0; issue_rd = 0; id_rR1 = 0; id_rR2 = 0; id_wR = 0;

        // reset with activity on every input: outputs stay 0, issue ignored
        tbl.push_back(mk(1, 1,3,32'h1111, 1,4,32'h2222, 1,5, 0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1, 1,3,32'h1111, 1,4,32'h2222, 1,5, 0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0,0,0));
        // pipe only, then pipe to x0
        tbl.push_back(mk(0, 1,3,32'hDEADBEEF, 0,0,0, 0,0, 0,0,0, 0,0,0,1,3,32'hDEADBEEF,0));
        tbl.push_back(mk(0, 1,0,32'hDEADBEEF, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0,0,0));
        // scoreboard: issue x7, hazards, release
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 1,7, 0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 7,0,0, 0,0,1,0,0,0,32'h80));
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 0,0,7, 0,0,1,0,0,0,32'h80));
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 0,8,0, 0,0,0,0,0,0,32'h80));
        tbl.push_back(mk(0, 0,0,0, 1,7,32'h55, 0,0, 7,0,0, 0,1,1,1,7,32'h55,32'h80));
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 7,0,0, 0,0,0,0,0,0,0));
        // contention: four denials then forced long grant, twice in a row
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++)
                tbl.push_back(mk(0, 1,4,DA, 1,6,DB, 0,0, 0,0,0, 0,0,0,1,4,DA,0));
            tbl.push_back(mk(0, 1,4,DA, 1,6,DB, 0,0, 0,0,0, 1,1,0,1,6,DB,0));
        end
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0,0,0));
        // x0: issue to x0 ignored; long result to x0 accepted without write
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 1,0, 0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0, 0,0,0, 1,0,32'h77, 0,0, 0,0,0, 0,1,0,0,0,0,0));
        // set/clear collision on x9: set wins, later clear
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 1,9, 0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0, 0,0,0, 1,9,32'h99, 1,9, 0,0,0, 0,1,0,1,9,32'h99,32'h200));
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 0,9,0, 0,0,1,0,0,0,32'h200));
        tbl.push_back(mk(0, 0,0,0, 1,9,32'h9A, 0,0, 0,0,0, 0,1,0,1,9,32'h9A,32'h200));
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 0,9,0, 0,0,0,0,0,0,0));
        // reset mid-operation discards x12
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 1,12, 0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 12,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 12,0,0, 0,0,0,0,0,0,0));
        // pipe to x0 does not block a long result
        tbl.push_back(mk(0, 1,0,32'h5, 1,3,32'h33, 0,0, 0,0,0, 0,1,0,1,3,32'h33,0));

        step = 0;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            sample(step);
            step++;
        end

        // random WB-only traffic against a simple model
        for (int i = 0; i < 24; i++) begin
            vec_t v;
            logic          we_r;
            logic [4:0]    wr_r;
            logic [DW-1:0] wd_r;
            logic          hit;
            we_r = 1'($urandom_range(0, 1));
            wr_r = 5'($urandom_range(0, 31));
            wd_r = $urandom;
            hit  = we_r && (wr_r != 5'd0);
            v = mk(0, we_r, wr_r, wd_r, 0,0,0, 0,0, 0,0,0,
                   0, 0, 0, hit, hit ? wr_r : 5'd0, hit ? wd_r : '0, 0);
            drive(v);
            sample(step);
            step++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between the pipeline writeback stage and a multi-cycle unit (divider/load) that returns results out of order with the pipeline.
- Keeps a 32-bit busy scoreboard of destinations owned by in-flight multi-cycle ops and stalls decode on RAW/WAW hits.
- Guarantees the multi-cycle unit forward progress with a starvation limit.
- Sits between WB, the multi-cycle unit, the decode stage and the register file.

Parameters:
- DW, 32, data width of write data.
- STARVE_LIMIT, 4, consecutive denied cycles of long_valid before the long unit is forced onto the port (legal range 1..15).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- pipe_we  in  1  WB stage write request
- pipe_wR  in  5  WB destination register
- pipe_wD  in  DW  WB write data
- pipe_hold  out  1  WB write not taken this cycle; WB must re-present the same request next cycle
- long_valid  in  1  multi-cycle result valid
- long_wR  in  5  multi-cycle destination register
- long_wD  in  DW  multi-cycle result data
- long_ready  out  1  multi-cycle result accepted this cycle (transfer = long_valid & long_ready)
- issue_valid  in  1  multi-cycle op issued this cycle
- issue_rd  in  5  destination of the issued op
- id_rR1  in  5  decode source 1
- id_rR2  in  5  decode source 2
- id_wR  in  5  decode destination
- id_stall  out  1  decode must stall
- rf_we  out  1  register-file write enable
- rf_wR  out  5  register-file write address
- rf_wD  out  DW  register-file write data
- busy_vec  out  32  scoreboard state, for debug

Behaviour:
- Reset: while rst=1, busy=0, starve counter=0, and all outputs are forced to 0. Reset mid-operation discards pending scoreboard entries. The held WB request is not retained by this block.
- Effective requests: pipe_req = pipe_we & (pipe_wR!=0). long_req = long_valid. Writes to x0 never consume the port. A long transfer with long_wR=0 is accepted without driving rf_we.
- Arbitration is combinational with zero latency. The write commits at the same edge as the grant.
- Normal mode (cnt < STARVE_LIMIT):
  - If pipe_req, the pipe wins: pipe_hold=0, long_ready=0.
  - Otherwise long_ready = long_valid.
- Force mode (cnt == STARVE_LIMIT):
  - long_ready=1.
  - pipe_hold = pipe_req.
  - The port carries the long request.
- Port mux: rf_we=1 with the winner's wR/wD when the winner's address is nonzero; otherwise rf_we=0 and rf_wR/rf_wD are 0.
- Starve counter (sequential):
  - 0 on any long transfer.
  - +1 when long_valid & !long_ready, saturating at STARVE_LIMIT.
  - Unchanged otherwise.
- Scoreboard (sequential, per bit r):
  - Set at the edge where issue_valid & issue_rd==r & r!=0.
  - Cleared at the edge of a long transfer with long_wR==r.
  - Simultaneous set and clear of the same r: set wins.
  - Bit 0 is always 0.
- id_stall (combinational) = busy[id_rR1] | busy[id_rR2] | busy[id_wR], with busy indexed at current state.
  - A reader in the cycle of the releasing write still stalls.
  - It proceeds the next cycle and reads the committed value.
- The issuer must not issue to a busy rd; id_stall blocks it. Issuing while id_stall=1 is a protocol error with undefined effect.
- busy_vec = current scoreboard.

Test Plan:
- Reset: rst=1 for 2 cycles with issue_valid=1, issue_rd=5 -> busy_vec=0, rf_we=0, id_stall=0; after release, busy_vec=0.
- Pipe only: pipe_we=1, pipe_wR=3, pipe_wD=0xDEADBEEF -> same cycle rf_we=1, rf_wR=3, rf_wD=0xDEADBEEF, pipe_hold=0. Then pipe_wR=0 -> rf_we=0.
- Scoreboard: issue_rd=7; next cycle id_rR1=7 -> id_stall=1. id_wR=7 also stalls, id_rR2=8 alone does not. Long transfer long_wR=7, wD=0x55 -> rf_we=1, id_stall still 1 that cycle, 0 the next; busy_vec[7]=0.
- Contention: pipe_req and long_valid both high -> pipe granted, long_ready=0 for cycles 1-4. Cycle 5 (cnt=4) -> long_ready=1, pipe_hold=1, rf_wR=long_wR. Cycle 6 -> pipe granted, counter=0.
- x0 handling: issue_rd=0 -> busy_vec unchanged. Long transfer with long_wR=0 -> long_ready=1, rf_we=0.
- Set/clear collision: busy[9]=1, long transfer wR=9 and issue_rd=9 same cycle -> busy[9] stays 1.
